// File: rtl/rotate_pipe.sv
// rotate_pipe: rotates unsigned screen points about a registered pivot/sin/cos pose, clamps to screen range.
// Latency: 4 clocks from acceptance to out_valid (S1 capture, S2 multiply, S3 sum/round, S4 clamp).
// Backpressure: all stages advance together when the output is empty or taken; in_ready = ~out_valid | out_ready.
//
// Ports:
//   clk, rst            : clock, asynchronous active-high reset (clears pipeline and pose)
//   pose_load           : latch pivot_x/pivot_y/sin_in/cos_in into the pose register (never stalls)
//   in_valid/in_ready   : point handshake for pt_x/pt_y
//   out_valid/out_ready : result handshake for out_x/out_y/out_clip
//   busy                : any pipeline stage holds a valid point
module rotate_pipe #(
    parameter int W    = 10,
    parameter int FRAC = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pose_load,
    input  logic [W-1:0]           pivot_x,
    input  logic [W-1:0]           pivot_y,
    input  logic signed [FRAC+1:0] sin_in,
    input  logic signed [FRAC+1:0] cos_in,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [W-1:0]           pt_x,
    input  logic [W-1:0]           pt_y,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [W-1:0]           out_x,
    output logic [W-1:0]           out_y,
    output logic                   out_clip,
    output logic                   busy
);
    localparam int TW = FRAC + 2;      // trig width (Q1.FRAC signed)
    localparam int DW = W + 1;         // signed offset from pivot
    localparam int PW = W + FRAC + 3;  // product width
    localparam int SW = W + FRAC + 4;  // sum width, also used for the rounded result

    localparam logic signed [TW-1:0] TRIG_ONE  = TW'(1 << FRAC);
    localparam logic signed [SW-1:0] RND_HALF  = SW'(1 << (FRAC - 1));
    localparam logic signed [SW-1:0] COORD_MAX = SW'((1 << W) - 1);

    typedef struct packed {
        logic [W-1:0]  px;
        logic [W-1:0]  py;
        logic [TW-1:0] s;
        logic [TW-1:0] c;
    } pose_t;

    pose_t pose_q;
    logic  adv;

    // S1: offsets and pose snapshot
    logic                 s1_vld;
    logic signed [DW-1:0] s1_dx;
    logic signed [DW-1:0] s1_dy;
    logic signed [TW-1:0] s1_sin;
    logic signed [TW-1:0] s1_cos;
    logic [W-1:0]         s1_px;
    logic [W-1:0]         s1_py;

    // S2: products
    logic                 s2_vld;
    logic signed [PW-1:0] s2_cdx;
    logic signed [PW-1:0] s2_sdy;
    logic signed [PW-1:0] s2_sdx;
    logic signed [PW-1:0] s2_cdy;
    logic [W-1:0]         s2_px;
    logic [W-1:0]         s2_py;

    // S3: rounded, pivot-added result (kept at full sum width so clamping sees the true value)
    logic                 s3_vld;
    logic signed [SW-1:0] s3_x;
    logic signed [SW-1:0] s3_y;

    logic signed [SW-1:0] sum_x;
    logic signed [SW-1:0] sum_y;
    logic signed [SW-1:0] res_x;
    logic signed [SW-1:0] res_y;

    logic [W-1:0] clamp_x;
    logic [W-1:0] clamp_y;
    logic         clip_x;
    logic         clip_y;

    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;
    assign busy     = s1_vld | s2_vld | s3_vld | out_valid;

    // Pose register updates independently of the pipeline; S1 samples the
    // pre-edge value, so a point accepted alongside a load uses the old pose.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pose_q.px <= '0;
            pose_q.py <= '0;
            pose_q.s  <= '0;
            pose_q.c  <= TRIG_ONE;
        end else if (pose_load) begin
            pose_q.px <= pivot_x;
            pose_q.py <= pivot_y;
            pose_q.s  <= sin_in;
            pose_q.c  <= cos_in;
        end
    end

    // S3 arithmetic: round half toward +inf by adding half an LSB before the arithmetic shift.
    always_comb begin
        sum_x = SW'(s2_cdx) - SW'(s2_sdy);
        sum_y = SW'(s2_sdx) + SW'(s2_cdy);
        res_x = ((sum_x + RND_HALF) >>> FRAC) + $signed(SW'({1'b0, s2_px}));
        res_y = ((sum_y + RND_HALF) >>> FRAC) + $signed(SW'({1'b0, s2_py}));
    end

    // S4 clamp to [0, 2^W-1].
    always_comb begin
        clamp_x = s3_x[W-1:0];
        clip_x  = 1'b0;
        if (s3_x[SW-1]) begin
            clamp_x = '0;
            clip_x  = 1'b1;
        end else if (s3_x > COORD_MAX) begin
            clamp_x = '1;
            clip_x  = 1'b1;
        end

        clamp_y = s3_y[W-1:0];
        clip_y  = 1'b0;
        if (s3_y[SW-1]) begin
            clamp_y = '0;
            clip_y  = 1'b1;
        end else if (s3_y > COORD_MAX) begin
            clamp_y = '1;
            clip_y  = 1'b1;
        end
    end

    // Single shift enable for every stage: bubbles are kept during a stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld    <= 1'b0;
            s1_dx     <= '0;
            s1_dy     <= '0;
            s1_sin    <= '0;
            s1_cos    <= '0;
            s1_px     <= '0;
            s1_py     <= '0;
            s2_vld    <= 1'b0;
            s2_cdx    <= '0;
            s2_sdy    <= '0;
            s2_sdx    <= '0;
            s2_cdy    <= '0;
            s2_px     <= '0;
            s2_py     <= '0;
            s3_vld    <= 1'b0;
            s3_x      <= '0;
            s3_y      <= '0;
            out_valid <= 1'b0;
            out_x     <= '0;
            out_y     <= '0;
            out_clip  <= 1'b0;
        end else if (adv) begin
            s1_vld <= in_valid;
            s1_dx  <= $signed({1'b0, pt_x}) - $signed({1'b0, pose_q.px});
            s1_dy  <= $signed({1'b0, pt_y}) - $signed({1'b0, pose_q.py});
            s1_sin <= pose_q.s;
            s1_cos <= pose_q.c;
            s1_px  <= pose_q.px;
            s1_py  <= pose_q.py;

            s2_vld <= s1_vld;
            s2_cdx <= PW'(s1_cos) * PW'(s1_dx);
            s2_sdy <= PW'(s1_sin) * PW'(s1_dy);
            s2_sdx <= PW'(s1_sin) * PW'(s1_dx);
            s2_cdy <= PW'(s1_cos) * PW'(s1_dy);
            s2_px  <= s1_px;
            s2_py  <= s1_py;

            s3_vld <= s2_vld;
            s3_x   <= res_x;
            s3_y   <= res_y;

            out_valid <= s3_vld;
            if (s3_vld) begin
                out_x    <= clamp_x;
                out_y    <= clamp_y;
                out_clip <= clip_x | clip_y;
            end
        end
    end
endmodule

// File: tb/tb_rotate_pipe.sv
// tb_rotate_pipe: self-checking bench for rotate_pipe against a real-arithmetic rotation model.
// Latency: checks the 4-edge acceptance-to-output latency explicitly.
// Backpressure: exercises random and directed out_ready stalls, same-cycle pose loads and mid-stream reset.
module tb_rotate_pipe;
    localparam int W    = 10;
    localparam int FRAC = 8;
    localparam int TW   = FRAC + 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 pose_load;
    logic [W-1:0]         pivot_x;
    logic [W-1:0]         pivot_y;
    logic signed [TW-1:0] sin_in;
    logic signed [TW-1:0] cos_in;
    logic                 in_valid;
    logic                 in_ready;
    logic [W-1:0]         pt_x;
    logic [W-1:0]         pt_y;
    logic                 out_valid;
    logic                 out_ready;
    logic [W-1:0]         out_x;
    logic [W-1:0]         out_y;
    logic                 out_clip;
    logic                 busy;

    always #5 clk = ~clk;

    rotate_pipe #(.W(W), .FRAC(FRAC)) dut (
        .clk(clk), .rst(rst), .pose_load(pose_load),
        .pivot_x(pivot_x), .pivot_y(pivot_y), .sin_in(sin_in), .cos_in(cos_in),
        .in_valid(in_valid), .in_ready(in_ready), .pt_x(pt_x), .pt_y(pt_y),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_x(out_x), .out_y(out_y), .out_clip(out_clip), .busy(busy)
    );

    typedef struct {
        int x;
        int y;
        bit clip;
    } exp_t;

    int   errors = 0;
    int   checks = 0;
    int   m_px, m_py, m_s, m_c;
    exp_t q[$];

    // Directed cases: load flag, pivot, sin, cos, point, expected x/y/clip.
    int d_ld[8]  = '{1, 0, 1, 1, 1, 1, 1, 0};
    int d_pvx[8] = '{320, 320, 0, 0, 0, 10, 1000, 1000};
    int d_pvy[8] = '{240, 240, 0, 0, 0, 0, 1000, 1000};
    int d_s[8]   = '{256, 256, 181, 0, 0, 0, 256, 256};
    int d_c[8]   = '{0, 0, 181, 128, -256, 128, 256, 256};
    int d_x[8]   = '{330, 320, 10, 1, 5, 9, 1023, 1023};
    int d_y[8]   = '{240, 230, 0, 0, 3, 0, 1000, 1023};
    int d_ex[8]  = '{320, 330, 7, 1, 0, 10, 1023, 1000};
    int d_ey[8]  = '{250, 240, 7, 0, 0, 0, 1023, 1023};
    int d_ec[8]  = '{0, 0, 0, 0, 1, 0, 0, 1};

    // Rotation about the pivot in real arithmetic; floor(v + 0.5) is round-half-up.
    function automatic exp_t model(input int x, input int y);
        exp_t e;
        int   dx, dy, rx, ry, lim;
        real  scale;
        scale  = real'(1 << FRAC);
        lim    = (1 << W) - 1;
        dx     = x - m_px;
        dy     = y - m_py;
        rx     = m_px + $rtoi($floor(real'(m_c * dx - m_s * dy) / scale + 0.5));
        ry     = m_py + $rtoi($floor(real'(m_s * dx + m_c * dy) / scale + 0.5));
        e.clip = 1'b0;
        if (rx < 0)        begin rx = 0;   e.clip = 1'b1; end
        else if (rx > lim) begin rx = lim; e.clip = 1'b1; end
        if (ry < 0)        begin ry = 0;   e.clip = 1'b1; end
        else if (ry > lim) begin ry = lim; e.clip = 1'b1; end
        e.x = rx;
        e.y = ry;
        return e;
    endfunction

    task automatic drive_pose(input int px, input int py, input int s, input int c);
        pivot_x = W'(px);
        pivot_y = W'(py);
        sin_in  = TW'(s);
        cos_in  = TW'(c);
    endtask

    task automatic set_model(input int px, input int py, input int s, input int c);
        m_px = px;
        m_py = py;
        m_s  = s;
        m_c  = c;
    endtask

    task automatic test_reset();
        rst = 1'b1; pose_load = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        pt_x = '0; pt_y = '0;
        drive_pose(0, 0, 0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid: got out_valid=%0b busy=%0b want 0 0", out_valid, busy);
        end
        checks++;
        if (out_x !== '0 || out_y !== '0 || out_clip !== 1'b0) begin
            errors++;
            $display("FAIL reset_data: got x=%0d y=%0d clip=%0b want 0 0 0", out_x, out_y, out_clip);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %0b want 1", in_ready);
        end
        set_model(0, 0, 0, 1 << FRAC);
    endtask

    task automatic test_identity_latency();
        int n;
        @(posedge clk); #1;
        in_valid = 1'b1; pt_x = W'(100); pt_y = W'(50); out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 1;
        while (out_valid !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL identity_latency: got %0d edges want 4", n);
        end
        checks++;
        if (out_valid !== 1'b1 || out_x !== W'(100) || out_y !== W'(50) || out_clip !== 1'b0) begin
            errors++;
            $display("FAIL identity_data: got v=%0b x=%0d y=%0d clip=%0b want 1 100 50 0",
                     out_valid, out_x, out_y, out_clip);
        end
    endtask

    task automatic test_directed();
        int n;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (d_ld[i] != 0) begin
                pose_load = 1'b1;
                drive_pose(d_pvx[i], d_pvy[i], d_s[i], d_c[i]);
                set_model(d_pvx[i], d_pvy[i], d_s[i], d_c[i]);
                @(posedge clk); #1;
                pose_load = 1'b0;
            end
            in_valid = 1'b1; pt_x = W'(d_x[i]); pt_y = W'(d_y[i]);
            @(posedge clk); #1;
            in_valid = 1'b0;
            n = 1;
            while (out_valid !== 1'b1 && n < 20) begin
                @(posedge clk); #1;
                n++;
            end
            checks++;
            if (out_valid !== 1'b1 || out_x !== W'(d_ex[i]) || out_y !== W'(d_ey[i]) ||
                out_clip !== d_ec[i][0]) begin
                errors++;
                $display("FAIL directed_%0d: got v=%0b x=%0d y=%0d clip=%0b want 1 %0d %0d %0d",
                         i, out_valid, out_x, out_y, out_clip, d_ex[i], d_ey[i], d_ec[i]);
            end
        end
    endtask

    task automatic test_random();
        bit         stall_prev = 1'b0;
        logic [W-1:0] hx = '0, hy = '0;
        logic       hc = 1'b0;
        exp_t       e;
        q.delete();
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(posedge clk); #1;
            in_valid  = (cyc < 500) && ($urandom_range(3) != 0);
            pt_x      = W'($urandom_range(1023));
            pt_y      = W'($urandom_range(1023));
            pose_load = (cyc < 500) && ($urandom_range(7) == 0);
            pivot_x   = W'($urandom_range(1023));
            pivot_y   = W'($urandom_range(1023));
            sin_in    = TW'(int'($urandom_range(512)) - 256);
            cos_in    = TW'(int'($urandom_range(512)) - 256);
            out_ready = (cyc >= 500) || ($urandom_range(2) != 0);
            @(negedge clk);
            checks++;
            if (in_ready !== (!out_valid || out_ready)) begin
                errors++;
                $display("FAIL rand_in_ready: got %0b want %0b", in_ready, (!out_valid || out_ready));
            end
            if (stall_prev) begin
                checks++;
                if (out_valid !== 1'b1 || out_x !== hx || out_y !== hy || out_clip !== hc) begin
                    errors++;
                    $display("FAIL rand_stall_hold: got v=%0b x=%0d y=%0d clip=%0b want 1 %0d %0d %0b",
                             out_valid, out_x, out_y, out_clip, hx, hy, hc);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL rand_unexpected: got x=%0d y=%0d want no output", out_x, out_y);
                end else begin
                    e = q.pop_front();
                    if (out_x !== W'(e.x) || out_y !== W'(e.y) || out_clip !== e.clip) begin
                        errors++;
                        $display("FAIL rand_data: got x=%0d y=%0d clip=%0b want %0d %0d %0b",
                                 out_x, out_y, out_clip, e.x, e.y, e.clip);
                    end
                end
            end
            if (in_valid && in_ready) q.push_back(model(int'(pt_x), int'(pt_y)));
            if (pose_load) set_model(int'(pivot_x), int'(pivot_y), int'(sin_in), int'(cos_in));
            stall_prev = out_valid && !out_ready;
            hx = out_x; hy = out_y; hc = out_clip;
        end
        pose_load = 1'b0;
        checks++;
        if (q.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rand_drain: got pending=%0d busy=%0b want 0 0", q.size(), busy);
        end
    endtask

    task automatic test_back_to_back();
        int   px[6] = '{600, 520, 700, 512, 450, 900};
        int   py[6] = '{400, 390, 300, 384, 500, 100};
        int   idx = 0, got = 0, stall_left = 0;
        bit   seen = 1'b0, stall_prev = 1'b0;
        logic [W-1:0] hx = '0, hy = '0;
        logic hc = 1'b0;
        exp_t e;
        q.delete();
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1; pose_load = 1'b1;
        drive_pose(512, 384, 181, 181);
        set_model(512, 384, 181, 181);
        for (int cyc = 0; cyc < 60 && got < 6; cyc++) begin
            @(posedge clk); #1;
            pose_load = 1'b0;
            if (out_valid && !seen) begin
                seen = 1'b1;
                stall_left = 6;
            end
            out_ready = (stall_left == 0);
            if (stall_left > 0) stall_left--;
            in_valid = (idx < 6);
            if (idx < 6) begin
                pt_x = W'(px[idx]);
                pt_y = W'(py[idx]);
            end
            @(negedge clk);
            if (out_valid && !out_ready) begin
                checks++;
                if (in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_in_ready: got %0b want 0", in_ready);
                end
                if (stall_prev) begin
                    checks++;
                    if (out_x !== hx || out_y !== hy || out_clip !== hc) begin
                        errors++;
                        $display("FAIL b2b_hold: got x=%0d y=%0d clip=%0b want %0d %0d %0b",
                                 out_x, out_y, out_clip, hx, hy, hc);
                    end
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_extra: got x=%0d y=%0d want no output", out_x, out_y);
                end else begin
                    e = q.pop_front();
                    if (out_x !== W'(e.x) || out_y !== W'(e.y) || out_clip !== e.clip) begin
                        errors++;
                        $display("FAIL b2b_data_%0d: got x=%0d y=%0d clip=%0b want %0d %0d %0b",
                                 got, out_x, out_y, out_clip, e.x, e.y, e.clip);
                    end
                end
                got++;
            end
            if (in_valid && in_ready) begin
                q.push_back(model(int'(pt_x), int'(pt_y)));
                idx++;
            end
            stall_prev = out_valid && !out_ready;
            hx = out_x; hy = out_y; hc = out_clip;
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        checks++;
        if (got != 6 || q.size() != 0 || seen != 1'b1) begin
            errors++;
            $display("FAIL b2b_count: got %0d outputs, %0d pending want 6 0", got, q.size());
        end
    endtask

    task automatic test_same_cycle_pose();
        int ox[2], oy[2];
        int got = 0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        pose_load = 1'b1; in_valid = 1'b0;
        drive_pose(0, 0, 0, 1 << FRAC);
        @(posedge clk); #1;
        drive_pose(320, 240, 256, 0);
        in_valid = 1'b1; pt_x = W'(330); pt_y = W'(240);
        @(posedge clk); #1;
        pose_load = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int cyc = 0; cyc < 20 && got < 2; cyc++) begin
            @(negedge clk);
            if (out_valid) begin
                ox[got] = int'(out_x);
                oy[got] = int'(out_y);
                got++;
            end
            @(posedge clk); #1;
        end
        set_model(320, 240, 256, 0);
        checks++;
        if (got != 2) begin
            errors++;
            $display("FAIL same_cycle_count: got %0d want 2", got);
        end else begin
            checks++;
            if (ox[0] != 330 || oy[0] != 240) begin
                errors++;
                $display("FAIL same_cycle_old_pose: got x=%0d y=%0d want 330 240", ox[0], oy[0]);
            end
            checks++;
            if (ox[1] != 320 || oy[1] != 250) begin
                errors++;
                $display("FAIL same_cycle_new_pose: got x=%0d y=%0d want 320 250", ox[1], oy[1]);
            end
        end
    endtask

    task automatic test_reset_midstream();
        bit stale = 1'b0;
        int n;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; pt_x = W'(100 + i * 10); pt_y = W'(50);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_inflight: got busy=%0b v=%0b want 1 0", busy, out_valid);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_drop: got v=%0b busy=%0b want 0 0", out_valid, busy);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        set_model(0, 0, 0, 1 << FRAC);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || busy !== 1'b0) stale = 1'b1;
        end
        checks++;
        if (stale) begin
            errors++;
            $display("FAIL midreset_stale: got stale output after reset want none");
        end
        @(posedge clk); #1;
        in_valid = 1'b1; pt_x = W'(100); pt_y = W'(50);
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 1;
        while (out_valid !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (out_valid !== 1'b1 || out_x !== W'(100) || out_y !== W'(50) || out_clip !== 1'b0) begin
            errors++;
            $display("FAIL midreset_pose_identity: got v=%0b x=%0d y=%0d clip=%0b want 1 100 50 0",
                     out_valid, out_x, out_y, out_clip);
        end
    endtask

    initial begin
        test_reset();
        test_identity_latency();
        test_directed();
        test_random();
        test_back_to_back();
        test_same_cycle_pose();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
